// File: rtl/axi_stream_strip_header.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_strip_header
// Function : Drops N leading header bytes per AXI-Stream packet and re-packs
//            the payload onto full MSB-aligned beats. Define
//            AXIS_STRIP_HDR_CAPTURE_EN to expose the stripped header bytes.
// Revision : 1.0  initial release
// ============================================================================
module axi_stream_strip_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
    output logic                    ready_strip
`ifdef AXIS_STRIP_HDR_CAPTURE_EN
    ,
    output logic                    hdr_valid,
    output logic [DATA_WD-1:0]      hdr_data,
    output logic [DATA_BYTE_WD-1:0] hdr_keep
`endif
);

    localparam int C_CNT_WD = $clog2(DATA_BYTE_WD + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_STREAM = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    function automatic logic [DATA_BYTE_WD-1:0] keep_of(input logic [C_CNT_WD-1:0] cnt);
        return ~({DATA_BYTE_WD{1'b1}} >> cnt);
    endfunction

    function automatic logic [C_CNT_WD-1:0] ones_of(input logic [DATA_BYTE_WD-1:0] v);
        logic [C_CNT_WD-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) c = c + {{(C_CNT_WD-1){1'b0}}, v[i]};
        return c;
    endfunction

    function automatic logic [DATA_WD-1:0] bit_mask_of(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    state_t                   state_q, state_d;
    logic [BYTE_CNT_WD-1:0]   n_q, n_d;
    logic [DATA_WD-1:0]       hold_data_q, hold_data_d;
    logic [C_CNT_WD-1:0]      hold_cnt_q, hold_cnt_d;
    logic                     valid_out_q, valid_out_d;
    logic [DATA_WD-1:0]       data_out_q, data_out_d;
    logic [DATA_BYTE_WD-1:0]  keep_out_q, keep_out_d;
    logic                     last_out_q, last_out_d;
    logic                     ready_strip_q, ready_strip_d;

    logic                     w_out_free;
    logic                     w_in_hs;
    logic [C_CNT_WD-1:0]      w_k;
    logic [C_CNT_WD-1:0]      w_n;
    logic [C_CNT_WD-1:0]      w_rem;
    logic                     w_k_gt_n;
    logic [DATA_WD-1:0]       w_din_m;
    logic [DATA_WD-1:0]       w_tail;
    logic [DATA_WD-1:0]       w_joined;

    // Input bytes outside keep are masked so every output byte beyond keep_out is zero.
    assign w_out_free = !valid_out_q || ready_out;
    assign w_in_hs    = valid_in && ready_in;
    assign w_k        = ones_of(keep_in);
    assign w_n        = C_CNT_WD'(n_q);
    assign w_rem      = C_CNT_WD'(DATA_BYTE_WD) - w_n;
    assign w_k_gt_n   = w_k > w_n;
    assign w_din_m    = data_in & bit_mask_of(keep_in);
    assign w_tail     = w_din_m << {n_q, 3'b000};
    assign w_joined   = hold_data_q | (w_din_m >> {w_rem, 3'b000});

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        hold_data_d = hold_data_q;
        hold_cnt_d  = hold_cnt_q;
        valid_out_d = valid_out_q && !ready_out;
        data_out_d  = data_out_q;
        keep_out_d  = keep_out_q;
        last_out_d  = last_out_q;
        ready_in    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (valid_strip && ready_strip_q) begin
                    n_d     = byte_strip_cnt;
                    state_d = S_FIRST;
                end
            end
            S_FIRST: begin
                ready_in = w_out_free;
                if (w_in_hs) begin
                    hold_data_d = w_tail;
                    hold_cnt_d  = w_k_gt_n ? (w_k - w_n) : '0;
                    if (!last_in)      state_d = S_STREAM;
                    else if (w_k_gt_n) state_d = S_FLUSH;
                    else               state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                ready_in = w_out_free;
                if (w_in_hs) begin
                    valid_out_d = 1'b1;
                    data_out_d  = w_joined;
                    keep_out_d  = {DATA_BYTE_WD{1'b1}};
                    last_out_d  = 1'b0;
                    hold_data_d = w_tail;
                    hold_cnt_d  = w_k_gt_n ? (w_k - w_n) : '0;
                    if (last_in && w_k_gt_n) begin
                        state_d = S_FLUSH;
                    end else if (last_in) begin
                        keep_out_d = keep_of(w_rem + w_k);
                        last_out_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                if (w_out_free) begin
                    valid_out_d = 1'b1;
                    data_out_d  = hold_data_q;
                    keep_out_d  = keep_of(hold_cnt_q);
                    last_out_d  = 1'b1;
                    hold_data_d = '0;
                    hold_cnt_d  = '0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_strip_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            n_q           <= '0;
            hold_data_q   <= '0;
            hold_cnt_q    <= '0;
            valid_out_q   <= 1'b0;
            data_out_q    <= '0;
            keep_out_q    <= '0;
            last_out_q    <= 1'b0;
            ready_strip_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            hold_data_q   <= hold_data_d;
            hold_cnt_q    <= hold_cnt_d;
            valid_out_q   <= valid_out_d;
            data_out_q    <= data_out_d;
            keep_out_q    <= keep_out_d;
            last_out_q    <= last_out_d;
            ready_strip_q <= ready_strip_d;
        end
    end

    assign valid_out   = valid_out_q;
    assign data_out    = data_out_q;
    assign keep_out    = keep_out_q;
    assign last_out    = last_out_q;
    assign ready_strip = ready_strip_q;

`ifdef AXIS_STRIP_HDR_CAPTURE_EN
    logic                    hdr_valid_q, hdr_valid_d;
    logic [DATA_WD-1:0]      hdr_data_q, hdr_data_d;
    logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_d;

    always_comb begin
        hdr_valid_d = 1'b0;
        hdr_data_d  = hdr_data_q;
        hdr_keep_d  = hdr_keep_q;
        if (state_q == S_FIRST && w_in_hs) begin
            hdr_valid_d = (n_q != '0);
            hdr_data_d  = data_in & ~({DATA_WD{1'b1}} >> {n_q, 3'b000});
            hdr_keep_d  = keep_of(w_n);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_valid_q <= 1'b0;
            hdr_data_q  <= '0;
            hdr_keep_q  <= '0;
        end else begin
            hdr_valid_q <= hdr_valid_d;
            hdr_data_q  <= hdr_data_d;
            hdr_keep_q  <= hdr_keep_d;
        end
    end

    assign hdr_valid = hdr_valid_q;
    assign hdr_data  = hdr_data_q;
    assign hdr_keep  = hdr_keep_q;
`endif

endmodule
`default_nettype wire
